triangle_scan: RTL and testbench

Sequential point-in-triangle rasteriser. Latches three vertices, walks every pixel of the triangle's bounding box in raster order, and emits one `(x, y, inside)` result per pixel over a valid/ready stream. The block is a parametrised successor to the combinational single-point inside test. It sits between the primitive source and the pixel/fragment consumer.

---
 rtl/triangle_scan.sv | 170 +++++++++++++++++
 tb/tb_triangle_scan.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/triangle_scan.sv
// Sequential point-in-triangle rasteriser: latches three vertices, walks the
// bounding box in raster order and streams (x, y, inside) per pixel.
module triangle_scan #(
  parameter int W         = 11,
  parameter bit INCL_EDGE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] y1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] y2,
  input  logic [W-1:0] x3,
  input  logic [W-1:0] y3,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_x,
  output logic [W-1:0] out_y,
  output logic         out_inside,
  output logic         done
);

  localparam int DW = 2 * W + 3;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SCAN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0][W-1:0]   vx_q, vx_d, vy_q, vy_d;
  logic [W-1:0]        xmin_q, xmin_d, xmax_q, xmax_d;
  logic [W-1:0]        ymin_q, ymin_d, ymax_q, ymax_d;
  logic [W-1:0]        px_q, px_d, py_q, py_d;
  logic                last_px;
  logic signed [DW-1:0] d12, d23, d31;
  logic                pos12, pos23, pos31, neg12, neg23, neg31;
  logic                inside_raw;

  function automatic logic [W-1:0] min3(input logic [W-1:0] a, b, c);
    logic [W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [W-1:0] max3(input logic [W-1:0] a, b, c);
    logic [W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Exact edge function; the widths leave headroom so no term can overflow.
  function automatic logic signed [DW-1:0] edge_d(input logic [W-1:0] ax, ay, bx, by, px, py);
    logic signed [W:0]     dax, day, dbx, dby;
    logic signed [2*W+1:0] pa, pb;
    dax = $signed({1'b0, ax} - {1'b0, px});
    day = $signed({1'b0, ay} - {1'b0, py});
    dbx = $signed({1'b0, bx} - {1'b0, px});
    dby = $signed({1'b0, by} - {1'b0, py});
    pa  = $signed({{(W+1){dax[W]}}, dax} * {{(W+1){dby[W]}}, dby});
    pb  = $signed({{(W+1){dbx[W]}}, dbx} * {{(W+1){day[W]}}, day});
    return $signed({pa[2*W+1], pa} - {pb[2*W+1], pb});
  endfunction

  assign last_px = (px_q == xmax_q) && (py_q == ymax_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SETUP;
      S_SETUP: state_d = S_SCAN;
      S_SCAN:  if (out_ready && last_px) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    out_valid  = (state_q == S_SCAN);
    done       = (state_q == S_DONE);
    out_inside = inside_raw && (state_q == S_SCAN);
  end

  // The final pixel holds its coordinate; no increment past xmax/ymax ever happens.
  always_comb begin
    vx_d   = vx_q;
    vy_d   = vy_q;
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    px_d   = px_q;
    py_d   = py_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          vx_d = {x3, x2, x1};
          vy_d = {y3, y2, y1};
        end
      end
      S_SETUP: begin
        xmin_d = min3(vx_q[0], vx_q[1], vx_q[2]);
        xmax_d = max3(vx_q[0], vx_q[1], vx_q[2]);
        ymin_d = min3(vy_q[0], vy_q[1], vy_q[2]);
        ymax_d = max3(vy_q[0], vy_q[1], vy_q[2]);
        px_d   = min3(vx_q[0], vx_q[1], vx_q[2]);
        py_d   = min3(vy_q[0], vy_q[1], vy_q[2]);
      end
      S_SCAN: begin
        if (out_ready && !last_px) begin
          if (px_q < xmax_q) begin
            px_d = px_q + W'(1);
          end else begin
            px_d = xmin_q;
            py_d = py_q + W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vx_q   <= '0;
      vy_q   <= '0;
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
      px_q   <= '0;
      py_q   <= '0;
    end else begin
      vx_q   <= vx_d;
      vy_q   <= vy_d;
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
      px_q   <= px_d;
      py_q   <= py_d;
    end
  end

  always_comb begin
    d12   = edge_d(vx_q[0], vy_q[0], vx_q[1], vy_q[1], px_q, py_q);
    d23   = edge_d(vx_q[1], vy_q[1], vx_q[2], vy_q[2], px_q, py_q);
    d31   = edge_d(vx_q[2], vy_q[2], vx_q[0], vy_q[0], px_q, py_q);
    neg12 = d12[DW-1];
    neg23 = d23[DW-1];
    neg31 = d31[DW-1];
    pos12 = !d12[DW-1] && (d12 != '0);
    pos23 = !d23[DW-1] && (d23 != '0);
    pos31 = !d31[DW-1] && (d31 != '0);
    // Accepting either sign makes the test independent of vertex winding.
    if (INCL_EDGE)
      inside_raw = (!neg12 && !neg23 && !neg31) || (!pos12 && !pos23 && !pos31);
    else
      inside_raw = (pos12 && pos23 && pos31) || (neg12 && neg23 && neg31);
  end

  assign out_x = px_q;
  assign out_y = py_q;

endmodule

// File: tb/tb_triangle_scan.sv
// Directed bench for triangle_scan: strict and edge-inclusive instances run in
// lockstep on shared stimulus, checked against a half-plane reference.
module tb_triangle_scan;
  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst, start, out_ready;
  logic [W-1:0] x1, y1, x2, y2, x3, y3;
  logic         busy0, val0, ins0, done0;
  logic         busy1, val1, ins1, done1;
  logic [W-1:0] ox0, oy0, ox1, oy1;
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  triangle_scan #(.W(W), .INCL_EDGE(1'b0)) u_strict (
    .clk(clk), .rst(rst), .start(start),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
    .busy(busy0), .out_valid(val0), .out_ready(out_ready),
    .out_x(ox0), .out_y(oy0), .out_inside(ins0), .done(done0)
  );

  triangle_scan #(.W(W), .INCL_EDGE(1'b1)) u_edge (
    .clk(clk), .rst(rst), .start(start),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3),
    .busy(busy1), .out_valid(val1), .out_ready(out_ready),
    .out_x(ox1), .out_y(oy1), .out_inside(ins1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tri(input int ax, ay, bx, by, cx, cy);
    x1 = W'(ax); y1 = W'(ay);
    x2 = W'(bx); y2 = W'(by);
    x3 = W'(cx); y3 = W'(cy);
  endtask

  // kind 0: (0,0),(4,0),(0,4) in either order; 1: all vertices at one point;
  // 2: (2040,0),(2047,0),(2047,2047) expressed as half-planes.
  function automatic bit exp_inside(input int kind, input bit incl, input int x, input int y);
    case (kind)
      0: return incl ? (x + y <= 4) : (x > 0 && y > 0 && x + y < 4);
      1: return incl;
      default: return incl ? (2047 * (x - 2040) >= 7 * y)
                           : (y > 0 && x < 2047 && 2047 * (x - 2040) > 7 * y);
    endcase
  endfunction

  task automatic scan(input int kind, input int xmn, xmx, ymn, ymx,
                      input bit stall, input int abort_at, input int restart_at);
    int ex, ey, cnt, cyc, n;
    bit fin, held;
    logic [W-1:0] hx, hy;
    logic hi0, hi1;
    n = (xmx - xmn + 1) * (ymx - ymn + 1);
    ex = xmn; ey = ymn; cnt = 0; cyc = 0; fin = 0; held = 0;
    hx = '0; hy = '0; hi0 = 1'b0; hi1 = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    chk("busy_after_start", busy0, 1);
    chk("valid_in_setup", val0, 0);
    set_tri(3, 3, 3, 3, 3, 3);
    while (!fin && cyc < 40000) begin
      if (held) begin
        chk("hold_x", ox0, hx);
        chk("hold_y", oy0, hy);
        chk("hold_in_strict", ins0, hi0);
        chk("hold_in_edge", ins1, hi1);
      end
      held = 0;
      out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      start = (restart_at != 0 && cnt == restart_at);
      if (val0) begin
        chk("valid_edge_inst", val1, 1);
        if (out_ready) begin
          chk("x_strict", ox0, ex);
          chk("y_strict", oy0, ey);
          chk("x_edge", ox1, ex);
          chk("y_edge", oy1, ey);
          chk("in_strict", ins0, exp_inside(kind, 1'b0, ex, ey));
          chk("in_edge", ins1, exp_inside(kind, 1'b1, ex, ey));
          if (kind == 2 && ex == 2046 && ey == 1) chk("pt_2046_1", ins0, 1);
          if (kind == 2 && cnt == n - 1) begin
            chk("last_x", ox0, 2047);
            chk("last_y", oy0, 2047);
            chk("last_in_strict", ins0, 0);
            chk("last_in_edge", ins1, 1);
          end
          cnt++;
          if (ex < xmx) ex++;
          else begin ex = xmn; ey++; end
        end else begin
          held = 1; hx = ox0; hy = oy0; hi0 = ins0; hi1 = ins1;
        end
      end
      step();
      cyc++;
      start = 1'b0;
      if (abort_at != 0 && cnt == abort_at) begin
        rst = 1'b1;
        #1;
        chk("rst_busy", busy0, 0);
        chk("rst_valid", val0, 0);
        chk("rst_done", done0, 0);
        chk("rst_x", ox0, 0);
        chk("rst_y", oy0, 0);
        chk("rst_in_edge", ins1, 0);
        step();
        chk("rst_no_done", done0, 0);
        chk("rst_busy_held", busy1, 0);
        rst = 1'b0;
        return;
      end
      if (done0) fin = 1;
    end
    chk("done_seen", fin, 1);
    chk("pixel_count", cnt, n);
    if (!stall) chk("done_latency", cyc, n + 2);
    chk("busy_in_done", busy0, 1);
    chk("valid_in_done", val0, 0);
    chk("done_edge_inst", done1, 1);
    step();
    chk("done_one_cycle", done0, 0);
    chk("idle_busy", busy0, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    set_tri(0, 0, 0, 0, 0, 0);
    #2;
    chk("reset_busy", busy0, 0);
    chk("reset_valid", val0, 0);
    chk("reset_done", done0, 0);
    chk("reset_x", ox0, 0);
    chk("reset_y", oy0, 0);
    chk("reset_in_edge", ins1, 0);
    step();
    step();
    rst = 1'b0;
    step();

    set_tri(0, 0, 4, 0, 0, 4);
    scan(0, 0, 4, 0, 4, 1'b0, 0, 0);
    set_tri(0, 4, 4, 0, 0, 0);
    scan(0, 0, 4, 0, 4, 1'b0, 0, 0);

    set_tri(0, 0, 4, 0, 0, 4);
    scan(0, 0, 4, 0, 4, 1'b0, 10, 3);
    step();
    chk("abort_idle", busy0, 0);
    set_tri(0, 0, 4, 0, 0, 4);
    scan(0, 0, 4, 0, 4, 1'b0, 0, 0);

    set_tri(5, 5, 5, 5, 5, 5);
    scan(1, 5, 5, 5, 5, 1'b0, 0, 0);

    set_tri(2040, 0, 2047, 0, 2047, 2047);
    scan(2, 2040, 2047, 0, 2047, 1'b1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
